// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the writeback queue entry type.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] WB_SIZE_WORD = 2'b00;
    localparam logic [1:0] WB_SIZE_HALF = 2'b01;
    localparam logic [1:0] WB_SIZE_BYTE = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lane_extract.sv
// Byte/halfword lane select with sign or zero extension; words pass through.
module wb_lane_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        wb_size,
    input  logic              wb_signed,
    input  logic [1:0]        wb_offset,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (wb_offset)
            2'd0:    byte_lane = wb_data[7:0];
            2'd1:    byte_lane = wb_data[15:8];
            2'd2:    byte_lane = wb_data[23:16];
            default: byte_lane = wb_data[31:24];
        endcase
        half_lane = wb_offset[1] ? wb_data[31:16] : wb_data[15:0];
    end

    // Reserved size code behaves as a word access.
    always_comb begin
        case (wb_size)
            WB_SIZE_BYTE: result = {{24{wb_signed & byte_lane[7]}}, byte_lane};
            WB_SIZE_HALF: result = {{16{wb_signed & half_lane[15]}}, half_lane};
            default:      result = wb_data;
        endcase
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback queue feeding the register-file write port, with decode hazard flags.
module reg_writeback_unit
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        wb_size,
    input  logic              wb_signed,
    input  logic [1:0]        wb_offset,
    input  logic              rf_stall,
    output logic              rf_regWrite,
    output logic [REG_W-1:0]  rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [REG_W-1:0]  hz_reg1,
    input  logic [REG_W-1:0]  hz_reg2,
    output logic              hz_pending1,
    output logic              hz_pending2,
    output logic              idle
);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [DATA_W-1:0] ext_data;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    wb_entry_t        head;

    wb_lane_extract u_extract (
        .wb_data   (wb_data),
        .wb_size   (wb_size),
        .wb_signed (wb_signed),
        .wb_offset (wb_offset),
        .result    (ext_data)
    );

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push     = wb_valid && !full;
    assign pop      = !empty && !rf_stall;
    assign wb_ready = !full;
    assign head     = mem[rd_ptr];
    assign idle     = empty && !rf_regWrite;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dst: wb_reg, data: ext_data};
        end
    end

    // Pops never target the write slot in the same cycle: a push needs !full, a pop needs !empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // Register-0 entries still update the address/data registers but never strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_regWrite   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_regWrite <= pop && (head.dst != REG_ZERO);
            if (pop) begin
                rf_write_reg  <= head.dst;
                rf_write_data <= head.data;
            end
        end
    end

    always_comb begin
        hz_pending1 = rf_regWrite && (rf_write_reg == hz_reg1);
        hz_pending2 = rf_regWrite && (rf_write_reg == hz_reg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (mem[i].dst == hz_reg1)) hz_pending1 = 1'b1;
            if (entry_valid[i] && (mem[i].dst == hz_reg2)) hz_pending2 = 1'b1;
        end
        if (hz_reg1 == REG_ZERO) hz_pending1 = 1'b0;
        if (hz_reg2 == REG_ZERO) hz_pending2 = 1'b0;
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Random and directed stimulus for reg_writeback_unit, checked every cycle against a queue model.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic [1:0]  wb_size = '0;
    logic        wb_signed = 1'b0;
    logic [1:0]  wb_offset = '0;
    logic        rf_stall = 1'b0;
    logic        rf_regWrite;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [4:0]  hz_reg1 = '0;
    logic [4:0]  hz_reg2 = '0;
    logic        hz_pending1;
    logic        hz_pending2;
    logic        idle;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_reg = '0;
    logic [31:0] exp_data = '0;

    reg_writeback_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .wb_size       (wb_size),
        .wb_signed     (wb_signed),
        .wb_offset     (wb_offset),
        .rf_stall      (rf_stall),
        .rf_regWrite   (rf_regWrite),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .hz_reg1       (hz_reg1),
        .hz_reg2       (hz_reg2),
        .hz_pending1   (hz_pending1),
        .hz_pending2   (hz_pending2),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_extract(input logic [31:0] d, input logic [1:0] sz,
                                                  input logic sg, input logic [1:0] off);
        logic [31:0] x;
        case (sz)
            2'b10: begin
                x = (d >> (8 * off)) & 32'h0000_00FF;
                if (sg && x[7]) x = x | 32'hFFFF_FF00;
            end
            2'b01: begin
                x = (off[1] ? (d >> 16) : d) & 32'h0000_FFFF;
                if (sg && x[15]) x = x | 32'hFFFF_0000;
            end
            default: x = d;
        endcase
        return x;
    endfunction

    function automatic logic model_pending(input logic [4:0] h);
        if (h == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].r == h) return 1'b1;
        return exp_we && (exp_reg == h);
    endfunction

    task automatic compare_all();
        chk("wb_ready", wb_ready, q.size() < DEPTH);
        chk("idle", idle, (q.size() == 0) && !exp_we);
        chk("rf_regWrite", rf_regWrite, exp_we);
        chk("rf_write_reg", rf_write_reg, exp_reg);
        chk("rf_write_data", rf_write_data, exp_data);
        chk("hz_pending1", hz_pending1, model_pending(hz_reg1));
        chk("hz_pending2", hz_pending2, model_pending(hz_reg2));
    endtask

    // Advances the model by the edge that follows this step.
    task automatic model_edge();
        bit do_push;
        ent_t h;
        do_push = wb_valid && (q.size() < DEPTH);
        if ((q.size() > 0) && !rf_stall) begin
            h        = q.pop_front();
            exp_we   = (h.r != 5'd0);
            exp_reg  = h.r;
            exp_data = h.d;
        end else begin
            exp_we = 1'b0;
        end
        if (do_push) q.push_back('{r: wb_reg, d: model_extract(wb_data, wb_size, wb_signed, wb_offset)});
    endtask

    task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [1:0] sz,
                        input logic sg, input logic [1:0] off, input logic st,
                        input logic [4:0] h1, input logic [4:0] h2);
        @(negedge clk);
        wb_valid = v; wb_reg = r; wb_data = d; wb_size = sz;
        wb_signed = sg; wb_offset = off; rf_stall = st; hz_reg1 = h1; hz_reg2 = h2;
        #1;
        compare_all();
        model_edge();
    endtask

    task automatic idle_step(input logic st);
        step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'b00, st, 5'd0, 5'd0);
    endtask

    initial begin
        #2;
        chk("reset_wb_ready", wb_ready, 1'b1);
        chk("reset_idle", idle, 1'b1);
        chk("reset_regWrite", rf_regWrite, 1'b0);
        chk("reset_write_reg", rf_write_reg, 32'h0);
        chk("reset_write_data", rf_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Model pins against hand-computed extraction results.
        chk("model_byte_s", model_extract(32'hA5A5_80A5, 2'b10, 1'b1, 2'd2), 32'hFFFF_FFA5);
        chk("model_byte_u", model_extract(32'hA5A5_80A5, 2'b10, 1'b0, 2'd2), 32'h0000_00A5);
        chk("model_half_s", model_extract(32'h8001_0000, 2'b01, 1'b1, 2'd2), 32'hFFFF_8001);

        // Single word write: strobe two edges after acceptance, exactly one cycle.
        step(1'b1, 5'd3, 32'h1234_5678, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0);
        idle_step(1'b0);
        chk("word_no_early_strobe", rf_regWrite, 1'b0);
        idle_step(1'b0);
        chk("word_strobe", rf_regWrite, 1'b1);
        chk("word_reg", rf_write_reg, 32'd3);
        chk("word_data", rf_write_data, 32'h1234_5678);
        idle_step(1'b0);
        chk("word_strobe_drop", rf_regWrite, 1'b0);
        chk("word_idle", idle, 1'b1);

        // Lane extraction through the DUT.
        step(1'b1, 5'd4, 32'hA5A5_80A5, 2'b10, 1'b1, 2'd2, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd5, 32'hA5A5_80A5, 2'b10, 1'b0, 2'd2, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd6, 32'h8001_0000, 2'b01, 1'b1, 2'd2, 1'b0, 5'd0, 5'd0);
        chk("byte_s_data", rf_write_data, 32'hFFFF_FFA5);
        idle_step(1'b0);
        chk("byte_u_data", rf_write_data, 32'h0000_00A5);
        idle_step(1'b0);
        chk("half_s_data", rf_write_data, 32'hFFFF_8001);
        idle_step(1'b0);

        // Stall fills the queue; the fifth request is held until space frees.
        for (int k = 0; k < 4; k++)
            step(1'b1, 5'(10 + k), 32'(100 + k), 2'b00, 1'b0, 2'd0, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd14, 32'd104, 2'b00, 1'b0, 2'd0, 1'b1, 5'd0, 5'd0);
        chk("stall_full_ready", wb_ready, 1'b0);
        step(1'b1, 5'd14, 32'd104, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0);
        chk("stall_release_ready", wb_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 5'd14, 32'd104, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0);
            if (k == 0) chk("ready_after_pop", wb_ready, 1'b1);
            chk("drain_strobe", rf_regWrite, 1'b1);
            chk("drain_order", rf_write_reg, 32'(10 + k));
        end
        idle_step(1'b0);

        // Register 0 is dropped; register 7 follows; hazard on 7 tracks its lifetime.
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7);
        step(1'b1, 5'd7, 32'h0000_0077, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7);
        step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7);
        chk("r0_no_strobe", rf_regWrite, 1'b0);
        chk("r0_data_updated", rf_write_data, 32'hDEAD_BEEF);
        chk("r7_pending_queued", hz_pending2, 1'b1);
        chk("r0_never_pending", hz_pending1, 1'b0);
        step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7);
        chk("r7_strobe", rf_regWrite, 1'b1);
        chk("r7_reg", rf_write_reg, 32'd7);
        chk("r7_pending_strobe", hz_pending2, 1'b1);
        step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7);
        chk("r7_pending_clear", hz_pending2, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 6; n++) idle_step(1'b0);

        // Mid-cycle reset with three queued entries and a live strobe.
        for (int k = 0; k < 4; k++)
            step(1'b1, 5'(20 + k), 32'(200 + k), 2'b00, 1'b0, 2'd0, 1'b1, 5'd0, 5'd0);
        idle_step(1'b0);
        step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b1, 5'd21, 5'd20);
        chk("pre_reset_strobe", rf_regWrite, 1'b1);
        chk("pre_reset_pending", hz_pending1, 1'b1);
        rst_n = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk("rst_regWrite", rf_regWrite, 1'b0);
        chk("rst_write_reg", rf_write_reg, 32'h0);
        chk("rst_write_data", rf_write_data, 32'h0);
        chk("rst_ready", wb_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_pending1", hz_pending1, 1'b0);
        chk("rst_pending2", hz_pending2, 1'b0);
        q.delete();
        exp_we = 1'b0;
        exp_reg = '0;
        exp_data = '0;
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b0, 5'd21, 5'd22);
            chk("post_reset_no_strobe", rf_regWrite, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
